trinary_sync_sink: RTL and testbench
====================================

TRINARY_SYNC_SINK -- requirements
Module: trinary_sync_sink

Interface
REQ-001 SHALL have a single clock domain and an asynchronous, active-low reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port init, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port trinary, input, 3 bits: 3-rail one-hot NCL wavefront; DATA has one rail high, NULL has all rails low; asynchronous to clk.
REQ-005 SHALL have port trinaryCOMP, output, 1 bit: completion to upstream; high requests NULL, low requests DATA.
REQ-006 SHALL have port out_valid, output, 1 bit: FIFO head is valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-008 SHALL have port out_id, output, 2 bits: winner code at the FIFO head; 0=rail0, 1=rail1, 2=rail2.
REQ-009 SHALL have ports cnt0, cnt1, cnt2, output, 16 bits each: per-rail accepted-grant counters.
REQ-010 SHALL have port err_multi, output, 1 bit: sticky flag for a multi-rail wavefront.
REQ-011 SHALL have port fifo_full, output, 1 bit: FIFO holds 4 entries.

Function
REQ-012 SHALL pass trinary through a 2-flop synchronizer (s1, s2), then one history register s3 (s3 <= s2).
REQ-013 SHALL treat a wavefront as stable when s2 == s3.
REQ-014 SHALL implement an FSM with states WAIT_DATA and WAIT_NULL.
REQ-015 SHALL enter WAIT_DATA on reset.
- In WAIT_DATA: trinaryCOMP = 0.
- In WAIT_NULL: trinaryCOMP = 1.
- trinaryCOMP SHALL be driven from a register with no combinational path from trinary.
REQ-016 In WAIT_DATA, when s2 is stable and one-hot and the FIFO can accept, the block SHALL, on that edge:
- push the rail index;
- increment the matching counter;
- go to WAIT_NULL.
REQ-017 Latency: if the rail is first sampled high at edge k, the push and the rise of trinaryCOMP SHALL occur at edge k+3.
REQ-018 The FIFO can accept when count < 4, or when count == 4 with a pop on the same edge.
REQ-019 When the FIFO cannot accept, the block SHALL stay in WAIT_DATA with trinaryCOMP = 0, holding upstream in DATA; no push, no drop.
REQ-020 In WAIT_DATA, when s2 is stable with 2 or 3 rails high, the block SHALL:
- set err_multi;
- skip the push and the counter update;
- go to WAIT_NULL, so that upstream drains.
REQ-021 In WAIT_NULL, when s2 == 3'b000 and is stable, the block SHALL return to WAIT_DATA and drive trinaryCOMP = 0 on that edge.
REQ-022 A DATA pattern in WAIT_NULL SHALL be ignored.
REQ-023 The FIFO SHALL have 4 entries of 2 bits, be first-word fall-through, and use 2-bit pointers that wrap 3 -> 0.
- out_valid = (count != 0).
- Pop occurs when out_valid && out_ready.
REQ-024 With a simultaneous push and pop, count SHALL be unchanged; at count == 0 no pop occurs and the push is taken.
REQ-025 out_id SHALL be don't-care when out_valid = 0, and SHALL be held stable while out_valid && !out_ready.
REQ-026 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-027 err_multi SHALL be cleared only by reset.

Reset
REQ-028 While init = 0, the block SHALL clear asynchronously:
- s1, s2, s3 = 0;
- FSM = WAIT_DATA, trinaryCOMP = 0;
- FIFO pointers and count = 0, out_valid = 0, fifo_full = 0;
- out_id = 0, cnt0/1/2 = 0, err_multi = 0.
REQ-029 Reset asserted mid-handshake SHALL discard FIFO contents and any wavefront in flight; after release the block SHALL wait for a fresh stable wavefront.
REQ-030 The first active edge after init rises SHALL be the first edge that samples trinary.

Verification
REQ-031 trinary = 3'b010 held, out_ready = 1 -> trinaryCOMP rises at edge k+3, out_valid = 1 with out_id = 1, cnt1 = 1; trinary = 0 -> trinaryCOMP falls at edge 3 after NULL is first sampled.
REQ-032 Six DATA/NULL cycles on rails 0,1,2,0,1,2 with out_ready = 0 -> four pushes, fifo_full = 1, fifth DATA held with trinaryCOMP = 0; pulsing out_ready for one cycle -> pops id 0, fifth wavefront accepted (id 1).
REQ-033 trinary = 3'b101 -> err_multi = 1, no push, counters unchanged, trinaryCOMP = 1 until NULL; err_multi still 1 after 10 further good wavefronts.
REQ-034 cnt2 preloaded by 65535 rail-2 wavefronts -> cnt2 = 16'hFFFF; one more -> stays 16'hFFFF, push still occurs.
REQ-035 init pulled low while in WAIT_NULL with 3 FIFO entries -> all outputs equal reset values immediately; trinaryCOMP = 0 without waiting for clk.
REQ-036 A 1-cycle glitch on trinary[0] shorter than one clk period -> no push, no state change.

Source files
------------

// File: rtl/trinary_sync_sink.sv
// Sink for a 3-rail NCL channel: synchronizes wavefronts into clk,
// records the winning rail in a 4-deep FWFT FIFO and keeps per-rail counts.
module trinary_sync_sink (
  input  logic        clk,
  input  logic        init,
  input  logic [2:0]  trinary,
  output logic        trinaryCOMP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_id,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
  output logic [15:0] cnt2,
  output logic        err_multi,
  output logic        fifo_full
);

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;
  logic       stable;
  logic       is_null;
  logic       is_one;
  logic       is_multi;
  logic [1:0] rail;
  logic [1:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] count;
  logic       pop;
  logic       can_acc;
  logic       push;
  logic       set_err;

  always_comb begin
    stable   = (s2 == s3);
    is_null  = (s2 == 3'b000);
    is_one   = $onehot(s2);
    is_multi = !is_null && !is_one;
    rail     = 2'd0;
    if (is_one) begin
      unique case (1'b1)
        s2[0]: rail = 2'd0;
        s2[1]: rail = 2'd1;
        s2[2]: rail = 2'd2;
      endcase
    end
  end

  // A full FIFO still accepts when the head leaves on the same edge.
  assign pop     = out_valid && out_ready;
  assign can_acc = (count != 3'd4) || pop;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      WAIT_DATA: begin
        if (stable && is_one && can_acc) begin
          push     = 1'b1;
          state_nx = WAIT_NULL;
        end else if (stable && is_multi) begin
          set_err  = 1'b1;
          state_nx = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (stable && is_null) begin
          state_nx = WAIT_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      state <= WAIT_DATA;
    end else begin
      s1    <= trinary;
      s2    <= s1;
      s3    <= s2;
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= rail;
        wp      <= wp + 2'd1;
      end
      if (pop) begin
        rp <= rp + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      cnt0      <= '0;
      cnt1      <= '0;
      cnt2      <= '0;
      err_multi <= 1'b0;
    end else begin
      if (push && rail == 2'd0 && cnt0 != 16'hFFFF) begin
        cnt0 <= cnt0 + 16'd1;
      end
      if (push && rail == 2'd1 && cnt1 != 16'hFFFF) begin
        cnt1 <= cnt1 + 16'd1;
      end
      if (push && rail == 2'd2 && cnt2 != 16'hFFFF) begin
        cnt2 <= cnt2 + 16'd1;
      end
      if (set_err) begin
        err_multi <= 1'b1;
      end
    end
  end

  assign trinaryCOMP = (state == WAIT_NULL);
  assign out_valid   = (count != 3'd0);
  assign fifo_full   = (count == 3'd4);
  assign out_id      = mem[rp];

endmodule

// File: tb/tb_trinary_sync_sink.sv
// Directed bench for trinary_sync_sink with a queue of expected
// winner codes popped as the FIFO head is consumed.
module tb_trinary_sync_sink;

  logic        clk;
  logic        init;
  logic [2:0]  trinary;
  logic        trinaryCOMP;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [15:0] cnt2;
  logic        err_multi;
  logic        fifo_full;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q [$];

  trinary_sync_sink dut (
    .clk         (clk),
    .init        (init),
    .trinary     (trinary),
    .trinaryCOMP (trinaryCOMP),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .err_multi   (err_multi),
    .fifo_full   (fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_comp(input logic v, input string tag);
    int n = 0;
    while (trinaryCOMP !== v && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, trinaryCOMP}, {31'd0, v});
  endtask

  task automatic send(input int r);
    logic [2:0] one;
    one = 3'b001;
    trinary = one << r;
    wait_comp(1'b1, "accept");
    exp_q.push_back(r[1:0]);
    if (out_ready) begin
      chk("send_id", {30'd0, out_id}, {30'd0, exp_q.pop_front()});
    end
    trinary = 3'b000;
    wait_comp(1'b0, "null");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_comp"},  {31'd0, trinaryCOMP}, 0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_full"},  {31'd0, fifo_full}, 0);
    chk({tag, "_id"},    {30'd0, out_id}, 0);
    chk({tag, "_cnt0"},  {16'd0, cnt0}, 0);
    chk({tag, "_cnt1"},  {16'd0, cnt1}, 0);
    chk({tag, "_cnt2"},  {16'd0, cnt2}, 0);
    chk({tag, "_err"},   {31'd0, err_multi}, 0);
  endtask

  initial begin
    init      = 1'b1;
    trinary   = 3'b000;
    out_ready = 1'b0;
    #1 init   = 1'b0;
    tick();
    tick();
    chk_reset("rst");
    #3 init = 1'b1;
    tick();

    // latency: edge k samples DATA, comp rises at k+3
    out_ready = 1'b1;
    trinary   = 3'b010;
    exp_q.push_back(2'd1);
    tick();
    tick();
    tick();
    chk("lat_comp_lo", {31'd0, trinaryCOMP}, 0);
    tick();
    chk("lat_comp_hi", {31'd0, trinaryCOMP}, 1);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_id", {30'd0, out_id}, {30'd0, exp_q.pop_front()});
    chk("lat_cnt1", {16'd0, cnt1}, 1);
    trinary = 3'b000;
    tick();
    tick();
    tick();
    chk("nul_comp_hi", {31'd0, trinaryCOMP}, 1);
    chk("nul_popped", {31'd0, out_valid}, 0);
    tick();
    chk("nul_comp_lo", {31'd0, trinaryCOMP}, 0);

    // sub-period glitch straddling one edge
    out_ready = 1'b0;
    #4 trinary = 3'b001;
    #6 trinary = 3'b000;
    for (int i = 0; i < 6; i++) tick();
    chk("gl_comp", {31'd0, trinaryCOMP}, 0);
    chk("gl_valid", {31'd0, out_valid}, 0);
    chk("gl_cnt0", {16'd0, cnt0}, 0);

    // fill the FIFO, then backpressure holds upstream in DATA
    send(0);
    send(1);
    send(2);
    send(0);
    chk("fill_full", {31'd0, fifo_full}, 1);
    chk("fill_cnt0", {16'd0, cnt0}, 2);
    chk("fill_cnt1", {16'd0, cnt1}, 2);
    chk("fill_cnt2", {16'd0, cnt2}, 1);
    trinary = 3'b010;
    for (int i = 0; i < 8; i++) tick();
    chk("hold_comp", {31'd0, trinaryCOMP}, 0);
    chk("hold_cnt1", {16'd0, cnt1}, 2);
    out_ready = 1'b1;
    chk("pulse_id", {30'd0, out_id}, {30'd0, exp_q.pop_front()});
    tick();
    out_ready = 1'b0;
    exp_q.push_back(2'd1);
    chk("pulse_comp", {31'd0, trinaryCOMP}, 1);
    chk("pulse_full", {31'd0, fifo_full}, 1);
    trinary = 3'b000;
    wait_comp(1'b0, "pulse_null");
    trinary = 3'b100;
    for (int i = 0; i < 8; i++) tick();
    chk("hold6_comp", {31'd0, trinaryCOMP}, 0);
    exp_q.push_back(2'd2);
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      out_ready = 1'b1;
      chk("drain_valid", {31'd0, out_valid}, 1);
      chk("drain_id", {30'd0, out_id}, {30'd0, exp_q.pop_front()});
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 0);
    chk("drain_comp", {31'd0, trinaryCOMP}, 1);
    trinary = 3'b000;
    wait_comp(1'b0, "drain_null");
    chk("drain_cnt2", {16'd0, cnt2}, 2);

    // multi-rail wavefront
    trinary = 3'b101;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_err", {31'd0, err_multi}, 1);
    chk("mr_comp", {31'd0, trinaryCOMP}, 1);
    chk("mr_valid", {31'd0, out_valid}, 0);
    chk("mr_cnt0", {16'd0, cnt0}, 2);
    chk("mr_cnt2", {16'd0, cnt2}, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("mr_comp_held", {31'd0, trinaryCOMP}, 1);
    trinary = 3'b000;
    wait_comp(1'b0, "mr_null");
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(i % 3);
    chk("mr_sticky", {31'd0, err_multi}, 1);
    chk("mr10_cnt0", {16'd0, cnt0}, 6);
    chk("mr10_cnt1", {16'd0, cnt1}, 6);
    chk("mr10_cnt2", {16'd0, cnt2}, 5);

    // saturation: preload cnt2 one below the ceiling
    force dut.cnt2 = 16'hFFFE;
    #1 release dut.cnt2;
    send(2);
    chk("sat_first", {16'd0, cnt2}, 32'hFFFF);
    send(2);
    chk("sat_hold", {16'd0, cnt2}, 32'hFFFF);

    // async reset while in WAIT_NULL with three entries
    out_ready = 1'b0;
    send(0);
    send(1);
    trinary = 3'b100;
    wait_comp(1'b1, "ar_accept");
    chk("ar_valid", {31'd0, out_valid}, 1);
    #3 init = 1'b0;
    #1;
    chk_reset("ar");
    exp_q.delete();
    #2 init = 1'b1;
    tick();
    tick();
    tick();
    chk("post_comp_lo", {31'd0, trinaryCOMP}, 0);
    tick();
    chk("post_comp_hi", {31'd0, trinaryCOMP}, 1);
    chk("post_id", {30'd0, out_id}, 2);
    chk("post_cnt2", {16'd0, cnt2}, 1);
    trinary = 3'b000;
    wait_comp(1'b0, "post_null");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
